// File: rtl/ddr_line_reader_if.sv
// ddr_line_reader_if
//   Bundles the request, DDR command/read-data, output-beat and status
//   signals of ddr_line_reader. clk and rst_n stay outside the bundle.
//   master : the surrounding system (sequencer, DDR controller, FIFO)
//   slave  : ddr_line_reader itself
//   Request side  : calib_done, frame_start, buf_sel, fifo_space, err_clr
//   DDR side      : ddr_cmd_rdy, ddr_cmd_en, ddr_cmd, ddr_rd_addr,
//                   ddr_rd_data_valid, ddr_rd_data
//   Output beats  : out_valid, out_data, out_sol, out_eol
//   Status        : line_number, busy, frame_done, err_overrun
interface ddr_line_reader_if #(
    parameter int DATA_W  = 256,
    parameter int ADDR_W  = 29,
    parameter int SPACE_W = 12
);
    logic               calib_done;
    logic               frame_start;
    logic               buf_sel;
    logic [SPACE_W-1:0] fifo_space;
    logic               ddr_cmd_rdy;
    logic               ddr_cmd_en;
    logic [2:0]         ddr_cmd;
    logic [ADDR_W-1:0]  ddr_rd_addr;
    logic               ddr_rd_data_valid;
    logic [DATA_W-1:0]  ddr_rd_data;
    logic               out_valid;
    logic [DATA_W-1:0]  out_data;
    logic               out_sol;
    logic               out_eol;
    logic [7:0]         line_number;
    logic               busy;
    logic               frame_done;
    logic               err_overrun;
    logic               err_clr;

    modport master (
        output calib_done, frame_start, buf_sel, fifo_space, ddr_cmd_rdy,
               ddr_rd_data_valid, ddr_rd_data, err_clr,
        input  ddr_cmd_en, ddr_cmd, ddr_rd_addr, out_valid, out_data,
               out_sol, out_eol, line_number, busy, frame_done, err_overrun
    );

    modport slave (
        input  calib_done, frame_start, buf_sel, fifo_space, ddr_cmd_rdy,
               ddr_rd_data_valid, ddr_rd_data, err_clr,
        output ddr_cmd_en, ddr_cmd, ddr_rd_addr, out_valid, out_data,
               out_sol, out_eol, line_number, busy, frame_done, err_overrun
    );
endinterface

// File: rtl/ddr_line_reader.sv
// ddr_line_reader
//   Reads one video frame out of DDR, line by line. For each line it waits
//   until the downstream FIFO can take a whole line, issues LINE_BEATS read
//   bursts at contiguous addresses, and forwards the returned beats to the
//   FIFO tagged with start/end-of-line markers. All outputs are registered.
// Ports
//   clk, rst_n : system clock, asynchronous active-low reset
//   bus        : ddr_line_reader_if.slave (request, DDR, output, status)
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | no frame; waits for frame_start with calib_done
// LINE_WAIT | waits for FIFO room for one full line
// CMD       | issuing read bursts for the current line
// DATA      | all bursts issued; collecting the rest of the line's beats
// DONE      | one-cycle frame_done pulse, then back to IDLE
module ddr_line_reader #(
    parameter int                DATA_W     = 256,
    parameter int                ADDR_W     = 29,
    parameter int                LINE_BEATS = 30,
    parameter int                NUM_LINES  = 160,
    parameter int                ADDR_STEP  = 8,
    parameter logic [ADDR_W-1:0] BASE0      = '0,
    parameter logic [ADDR_W-1:0] BASE1      = 'h0100000,
    parameter int                SPACE_W    = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    ddr_line_reader_if.slave   bus
);

    localparam int CNT_W = $clog2(LINE_BEATS + 1);

    localparam logic [CNT_W-1:0]   BEATS_C    = CNT_W'(LINE_BEATS);
    localparam logic [CNT_W-1:0]   LAST_BEAT  = CNT_W'(LINE_BEATS - 1);
    localparam logic [7:0]         LAST_LINE  = 8'(NUM_LINES - 1);
    localparam logic [SPACE_W-1:0] SPACE_NEED = SPACE_W'(LINE_BEATS);
    localparam logic [ADDR_W-1:0]  STEP_C     = ADDR_W'(ADDR_STEP);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LINE_WAIT = 3'd1,
        CMD       = 3'd2,
        DATA      = 3'd3,
        DONE      = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic               cmd_en_q, cmd_en_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               out_valid_q, out_valid_d;
    logic [DATA_W-1:0]  out_data_q, out_data_d;
    logic               sol_q, sol_d;
    logic               eol_q, eol_d;
    logic [7:0]         line_q, line_d;
    logic               busy_q, busy_d;
    logic               frame_done_q, frame_done_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cmd_cnt_q, cmd_cnt_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;

    logic beat_ok;
    logic beat_drop;

    // Beats are only expected while bursts are outstanding for the current
    // line; anything else is a protocol slip on the DDR side.
    assign beat_ok   = bus.ddr_rd_data_valid
                       && ((state_q == CMD) || (state_q == DATA))
                       && (beat_cnt_q < BEATS_C);
    assign beat_drop = bus.ddr_rd_data_valid && !beat_ok;

    always_comb begin
        state_d      = state_q;
        cmd_en_d     = cmd_en_q;
        addr_d       = addr_q;
        out_valid_d  = 1'b0;
        out_data_d   = out_data_q;
        sol_d        = 1'b0;
        eol_d        = 1'b0;
        line_d       = line_q;
        err_d        = err_q;
        cmd_cnt_d    = cmd_cnt_q;
        beat_cnt_d   = beat_cnt_q;

        if (beat_ok) begin
            out_valid_d = 1'b1;
            out_data_d  = bus.ddr_rd_data;
            sol_d       = (beat_cnt_q == '0);
            eol_d       = (beat_cnt_q == LAST_BEAT);
            beat_cnt_d  = beat_cnt_q + CNT_W'(1);
        end

        // A fresh error in the same cycle as a clear must survive.
        if (bus.err_clr) begin
            err_d = 1'b0;
        end
        if (beat_drop) begin
            err_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (bus.frame_start && bus.calib_done) begin
                    addr_d  = bus.buf_sel ? BASE1 : BASE0;
                    line_d  = 8'd0;
                    state_d = LINE_WAIT;
                end
            end
            LINE_WAIT: begin
                if (bus.fifo_space >= SPACE_NEED) begin
                    cmd_en_d = 1'b1;
                    state_d  = CMD;
                end
            end
            CMD: begin
                if (cmd_en_q && bus.ddr_cmd_rdy) begin
                    addr_d    = addr_q + STEP_C;
                    cmd_cnt_d = cmd_cnt_q + CNT_W'(1);
                    if (cmd_cnt_q == LAST_BEAT) begin
                        cmd_en_d  = 1'b0;
                        cmd_cnt_d = '0;
                        state_d   = DATA;
                    end
                end
            end
            DATA: begin
                // beat_ok is false here, so beat_cnt_d has a single owner.
                if (beat_cnt_q == BEATS_C) begin
                    beat_cnt_d = '0;
                    if (line_q == LAST_LINE) begin
                        state_d = DONE;
                    end else begin
                        line_d  = line_q + 8'd1;
                        state_d = LINE_WAIT;
                    end
                end
            end
            DONE: begin
                line_d  = 8'd0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Registered from the next state so they line up with state_q.
        frame_done_d = (state_d == DONE);
        busy_d       = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cmd_en_q     <= 1'b0;
            addr_q       <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            sol_q        <= 1'b0;
            eol_q        <= 1'b0;
            line_q       <= 8'd0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
            cmd_cnt_q    <= '0;
            beat_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            cmd_en_q     <= cmd_en_d;
            addr_q       <= addr_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            sol_q        <= sol_d;
            eol_q        <= eol_d;
            line_q       <= line_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
            cmd_cnt_q    <= cmd_cnt_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

    assign bus.ddr_cmd     = 3'b001;
    assign bus.ddr_cmd_en  = cmd_en_q;
    assign bus.ddr_rd_addr = addr_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_data    = out_data_q;
    assign bus.out_sol     = sol_q;
    assign bus.out_eol     = eol_q;
    assign bus.line_number = line_q;
    assign bus.busy        = busy_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.err_overrun = err_q;

endmodule
